// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enable writeback, pending scoreboard and bulk-clear sweep; bypass under REGFILE_BYPASS_EN.
// Latency: reads combinational, writes/reserves/retires visible after the next edge, clear sweep takes DEPTH cycles.
// Backpressure: none; writes, reserves and clr_req are dropped while clr_busy is high.
module regfile_mp #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NRD    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_pend,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W/8-1:0]     wr_be,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_last,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;

    logic idle;
    logic wr_ok;
    logic retire_ok;
    logic rsv_ok;

    assign idle      = (state == ST_IDLE);
    assign wr_ok     = idle && wr_en && (wr_addr != '0);
    assign retire_ok = idle && wr_en && wr_last;
    assign rsv_ok    = idle && rsv_en && (rsv_addr != '0);

    assign clr_busy  = (state == ST_SWEEP);
    assign clr_done  = (state == ST_SWEEP) && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend  <= '0;
            state <= ST_IDLE;
            idx   <= '0;
        end else if (state == ST_SWEEP) begin
            mem[idx]  <= '0;
            pend[idx] <= 1'b0;
            idx       <= idx + 1'b1;
            if (idx == LAST_IDX) begin
                state <= ST_IDLE;
            end
        end else begin
            if (clr_req) begin
                state <= ST_SWEEP;
                idx   <= '0;
            end
            if (wr_ok) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            // Reserve is applied after retire so a same-address collision leaves the bit set.
            if (retire_ok) begin
                pend[wr_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                pend[rsv_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] word;
        a       = '0;
        word    = '0;
        rd_data = '0;
        rd_pend = '0;
        for (int k = 0; k < NRD; k++) begin
            a    = rd_addr[k*ADDR_W +: ADDR_W];
            word = mem[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && !reset && (wr_addr == a)) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        word[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
`endif
            if (a == '0) begin
                word = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = word;
            rd_pend[k]                  = (a != '0) && pend[a];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: fixed vector table, clear/reset sequences, then random traffic against a behavioural model.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         reset;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_pend;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [7:0]   wr_be;
    logic [63:0]  wr_data;
    logic         wr_last;
    logic         rsv_en;
    logic [4:0]   rsv_addr;
    logic         clr_req;
    logic         clr_busy;
    logic         clr_done;

    regfile_mp dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_last(wr_last),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: plain arrays plus an integer sweep counter.
    logic [63:0] m_mem  [32];
    bit          m_pend [32];
    bit          m_busy = 1'b0;
    int          m_idx  = 0;
    bit          s_busy, s_done;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        logic [63:0] v;
        if (a == 5'd0) return 64'd0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (!reset && !m_busy && wr_en && wr_addr == a)
            for (int b = 0; b < 8; b++)
                if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
`endif
        return v;
    endfunction

    function automatic void model_update();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 64'd0;
                m_pend[i] = 1'b0;
            end
            m_busy = 1'b0;
            m_idx  = 0;
        end else if (m_busy) begin
            m_mem[m_idx]  = 64'd0;
            m_pend[m_idx] = 1'b0;
            m_idx++;
            if (m_idx == 32) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end
        end else begin
            if (clr_req) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
            if (wr_en && wr_addr != 5'd0)
                for (int b = 0; b < 8; b++)
                    if (wr_be[b]) m_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            if (wr_en && wr_last) m_pend[wr_addr] = 1'b0;
            if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
        end
    endfunction

    function automatic void check_now(input string tag);
        logic [1:0] ep;
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s rd%0d", tag, k), rd_data[k*64 +: 64], exp_rd(rd_addr[k*5 +: 5]));
        ep[0] = (rd_addr[4:0] != 0) && m_pend[rd_addr[4:0]];
        ep[1] = (rd_addr[9:5] != 0) && m_pend[rd_addr[9:5]];
        chk({tag, " pend"}, 64'(rd_pend), 64'(ep));
        chk({tag, " busy"}, 64'(clr_busy), 64'(m_busy));
        chk({tag, " done"}, 64'(clr_done), 64'(m_busy && m_idx == 31));
        s_busy = clr_busy;
        s_done = clr_done;
    endfunction

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        check_now(tag);
        advance();
    endtask

    task automatic set_idle();
        reset = 0; wr_en = 0; wr_addr = 0; wr_be = 0; wr_data = 0; wr_last = 0;
        rsv_en = 0; rsv_addr = 0; clr_req = 0;
    endtask

    task automatic read_zero(input string tag, input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        @(negedge clk);
        chk({tag, " zero0"}, rd_data[63:0], 64'd0);
        chk({tag, " zero1"}, rd_data[127:64], 64'd0);
        chk({tag, " zpend"}, 64'(rd_pend), 64'd0);
        chk({tag, " idle"}, 64'(clr_busy), 64'd0);
        check_now(tag);
        advance();
    endtask

    task automatic fill_all();
        for (int r = 1; r < 32; r++) begin
            wr_en = 1; wr_addr = 5'(r); wr_be = 8'hFF; wr_data = {$urandom, $urandom};
            rsv_en = 1; rsv_addr = 5'(r);
            rd_addr = {5'(r), 5'(r - 1)};
            tick("fill");
        end
        set_idle();
    endtask

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [7:0]  wr_be;
        logic [63:0] wr_data;
        logic        wr_last;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  ra0, ra1;
        logic [63:0] e0, e1;
        logic [1:0]  ep;
    } vec_t;

`ifdef REGFILE_BYPASS_EN
    localparam logic [63:0] V1_SAME = 64'h1122334455667788;
    localparam logic [63:0] V2_SAME = 64'h11223344AAAAAAAA;
    localparam logic [63:0] V8_SAME = 64'h0000000000000055;
`else
    localparam logic [63:0] V1_SAME = 64'h0;
    localparam logic [63:0] V2_SAME = 64'h1122334455667788;
    localparam logic [63:0] V8_SAME = 64'h0;
`endif
    localparam logic [63:0] R5 = 64'h11223344AAAAAAAA;

    vec_t tab [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt, done_cnt, done_at, guard;

        tab[0]  = '{0, 0, 8'h00, 64'h0,                 0, 0, 0, 5, 7, 64'h0, 64'h0, 2'b00};
        tab[1]  = '{1, 5, 8'hFF, 64'h1122334455667788,  0, 0, 0, 5, 0, V1_SAME, 64'h0, 2'b00};
        tab[2]  = '{1, 5, 8'h0F, 64'hAAAAAAAAAAAAAAAA,  0, 0, 0, 5, 5, V2_SAME, V2_SAME, 2'b00};
        tab[3]  = '{0, 0, 8'h00, 64'h0,                 0, 0, 0, 5, 0, R5, 64'h0, 2'b00};
        tab[4]  = '{1, 0, 8'hFF, 64'hFFFFFFFFFFFFFFFF,  0, 1, 0, 0, 0, 64'h0, 64'h0, 2'b00};
        tab[5]  = '{0, 0, 8'h00, 64'h0,                 0, 0, 0, 0, 5, 64'h0, R5, 2'b00};
        tab[6]  = '{0, 0, 8'h00, 64'h0,                 0, 1, 7, 7, 0, 64'h0, 64'h0, 2'b00};
        tab[7]  = '{0, 0, 8'h00, 64'h0,                 0, 0, 0, 7, 7, 64'h0, 64'h0, 2'b11};
        tab[8]  = '{1, 7, 8'h01, 64'h55,                1, 1, 7, 7, 5, V8_SAME, R5, 2'b01};
        tab[9]  = '{0, 0, 8'h00, 64'h0,                 0, 0, 0, 7, 7, 64'h55, 64'h55, 2'b11};
        tab[10] = '{1, 7, 8'h00, 64'hFFFFFFFFFFFFFFFF,  1, 0, 0, 7, 7, 64'h55, 64'h55, 2'b11};
        tab[11] = '{0, 0, 8'h00, 64'h0,                 0, 0, 0, 7, 7, 64'h55, 64'h55, 2'b00};

        set_idle();
        rd_addr = 0;
        reset = 1;
        advance();
        advance();
        reset = 0;

        for (int i = 0; i < 32; i++) read_zero("reset", 5'(i), 5'(31 - i));

        for (int i = 0; i < 12; i++) begin
            wr_en = tab[i].wr_en; wr_addr = tab[i].wr_addr; wr_be = tab[i].wr_be;
            wr_data = tab[i].wr_data; wr_last = tab[i].wr_last;
            rsv_en = tab[i].rsv_en; rsv_addr = tab[i].rsv_addr;
            rd_addr = {tab[i].ra1, tab[i].ra0};
            @(negedge clk);
            chk($sformatf("vec%0d rd0", i), rd_data[63:0], tab[i].e0);
            chk($sformatf("vec%0d rd1", i), rd_data[127:64], tab[i].e1);
            chk($sformatf("vec%0d pend", i), 64'(rd_pend), 64'(tab[i].ep));
            check_now($sformatf("vec%0d", i));
            advance();
        end
        set_idle();

        // Full sweep with a write to r3 injected mid-sweep.
        fill_all();
        clr_req = 1;
        tick("clrreq");
        clr_req = 0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) begin
                wr_en = 1; wr_addr = 3; wr_be = 8'hFF; wr_data = 64'hFFFFFFFFFFFFFFFF;
            end else if (c == 6) begin
                set_idle();
            end
            rd_addr = {5'd3, 5'(c % 32)};
            tick("sweep");
            if (s_busy) busy_cnt++;
            if (s_done) begin
                done_cnt++;
                done_at = c;
            end
        end
        chk("busy_cycles", 64'(busy_cnt), 64'd32);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("done_at_last_busy", 64'(done_at), 64'd31);
        for (int i = 0; i < 32; i++) read_zero("after_clear", 5'(i), 5'(31 - i));

        // Reset lands while the sweep index is 10.
        fill_all();
        clr_req = 1;
        tick("clrreq2");
        clr_req = 0;
        for (int c = 0; c < 10; c++) tick("sweep2");
        reset = 1;
        tick("rst_in_sweep");
        reset = 0;
        for (int i = 0; i < 32; i++) read_zero("after_reset", 5'(i), 5'(31 - i));
        clr_req = 1;
        tick("clrreq3");
        clr_req = 0;
        @(negedge clk);
        chk("reclear_busy", 64'(clr_busy), 64'd1);
        check_now("reclear");
        advance();
        guard = 0;
        while (clr_busy && guard < 40) begin
            tick("sweep3");
            guard++;
        end
        chk("reclear_finished", 64'(clr_busy), 64'd0);

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            wr_en    = $urandom_range(0, 1);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_be    = 8'($urandom);
            wr_data  = {$urandom, $urandom};
            wr_last  = $urandom_range(0, 1);
            rsv_en   = $urandom_range(0, 1);
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            clr_req  = ($urandom_range(0, 63) == 0);
            rd_addr  = {($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31))};
            tick("rand");
        end
        set_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
